// File: rtl/fft_8point_dft_if.sv
// fft_8point_dft_if: AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tstrb/tlast/tuser) with master and slave views
interface fft_8point_dft_if #(
  parameter int DW = 64,
  parameter int UW = 1
);
  logic tvalid;
  logic tready;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tkeep;
  logic [DW/8-1:0] tstrb;
  logic tlast;
  logic [UW-1:0] tuser;
  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, input tready);
  modport slave (input tvalid, tdata, tkeep, tstrb, tlast, tuser, output tready);
endinterface

// File: rtl/fft_8point_dft.sv
// fft_8point_dft: 8-point DIF FFT; s_axis 8 x int8 samples in, m_axis 8 x (int32 re, int32 im) bins out, 4-register pipeline with one global stall
module fft_8point_dft #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TOUT_WIDTH = 512,
  parameter int C_AXIS_TUSER_WIDTH = 1
) (
  input logic s_axis_aclk,
  input logic s_axis_areset,
  fft_8point_dft_if.slave s_axis,
  fft_8point_dft_if.master m_axis
);
  typedef logic signed [31:0] w_t;
  localparam w_t C = 32'sd23170;
  logic en;
  logic unused_ok;
  logic [3:0] v_q, v_d, l_q, l_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] u_q [4];
  logic [C_AXIS_TUSER_WIDTH-1:0] u_d [4];
  w_t x_q [8];
  w_t x_d [8];
  w_t a_q [4];
  w_t a_d [4];
  w_t br_q [4];
  w_t br_d [4];
  w_t bi_q [4];
  w_t bi_d [4];
  w_t er_q [4];
  w_t er_d [4];
  w_t ei_q [4];
  w_t ei_d [4];
  w_t fr_q [4];
  w_t fr_d [4];
  w_t fi_q [4];
  w_t fi_d [4];
  w_t xr_q [8];
  w_t xr_d [8];
  w_t xi_q [8];
  w_t xi_d [8];
  w_t d [4];
  w_t p1, p3;
  assign en = ~(v_q[3] & ~m_axis.tready);
  assign s_axis.tready = en;
  assign m_axis.tvalid = v_q[3];
  assign m_axis.tlast = l_q[3];
  assign m_axis.tuser = u_q[3];
  assign m_axis.tkeep = '1;
  assign m_axis.tstrb = '1;
  assign unused_ok = ^{s_axis.tkeep, s_axis.tstrb};
  always_comb begin
    v_d = {v_q[2:0], s_axis.tvalid};
    l_d = {l_q[2:0], s_axis.tlast};
    u_d = '{s_axis.tuser, u_q[0], u_q[1], u_q[2]};
    for (int k = 0; k < C_AXIS_TDATA_WIDTH / 8; k++)
      x_d[k] = {{24{s_axis.tdata[8*k+7]}}, s_axis.tdata[8*k +: 8]};
    for (int k = 0; k < 4; k++) begin
      a_d[k] = x_q[k] + x_q[k+4];
      d[k] = x_q[k] - x_q[k+4];
    end
    p1 = (d[1] * C) >>> 15;
    p3 = (d[3] * C) >>> 15;
    br_d = '{d[0], p1, 32'sd0, -p3};
    bi_d = '{32'sd0, -p1, -d[2], -p3};
    er_d = '{a_q[0] + a_q[2], a_q[1] + a_q[3], a_q[0] - a_q[2], 32'sd0};
    ei_d = '{32'sd0, 32'sd0, 32'sd0, a_q[3] - a_q[1]};
    fr_d = '{br_q[0] + br_q[2], br_q[1] + br_q[3], br_q[0] - br_q[2], bi_q[1] - bi_q[3]};
    fi_d = '{bi_q[0] + bi_q[2], bi_q[1] + bi_q[3], bi_q[0] - bi_q[2], br_q[3] - br_q[1]};
    for (int m = 0; m < 2; m++) begin
      xr_d[2*m] = er_q[2*m] + er_q[2*m+1];
      xi_d[2*m] = ei_q[2*m] + ei_q[2*m+1];
      xr_d[2*m+4] = er_q[2*m] - er_q[2*m+1];
      xi_d[2*m+4] = ei_q[2*m] - ei_q[2*m+1];
      xr_d[2*m+1] = fr_q[2*m] + fr_q[2*m+1];
      xi_d[2*m+1] = fi_q[2*m] + fi_q[2*m+1];
      xr_d[2*m+5] = fr_q[2*m] - fr_q[2*m+1];
      xi_d[2*m+5] = fi_q[2*m] - fi_q[2*m+1];
    end
  end
  always_comb begin
    m_axis.tdata = '0;
    for (int k = 0; k < C_AXIS_TOUT_WIDTH / 64; k++)
      m_axis.tdata[64*k +: 64] = {xr_q[k], xi_q[k]};
  end
  always_ff @(posedge s_axis_aclk or negedge s_axis_areset) begin
    if (!s_axis_areset) begin
      v_q <= '0;
      l_q <= '0;
      u_q <= '{default: '0};
      x_q <= '{default: '0};
      a_q <= '{default: '0};
      br_q <= '{default: '0};
      bi_q <= '{default: '0};
      er_q <= '{default: '0};
      ei_q <= '{default: '0};
      fr_q <= '{default: '0};
      fi_q <= '{default: '0};
      xr_q <= '{default: '0};
      xi_q <= '{default: '0};
    end else if (en) begin
      v_q <= v_d;
      l_q <= l_d;
      u_q <= u_d;
      x_q <= x_d;
      a_q <= a_d;
      br_q <= br_d;
      bi_q <= bi_d;
      er_q <= er_d;
      ei_q <= ei_d;
      fr_q <= fr_d;
      fi_q <= fi_d;
      xr_q <= xr_d;
      xi_q <= xi_d;
    end
  end
endmodule

// File: tb/tb_fft_8point_dft.sv
// tb_fft_8point_dft: randomized and directed checks of fft_8point_dft against a DFT-4-of-decimated-halves reference model
module tb_fft_8point_dft;
  typedef struct {longint r; longint i;} cpx_t;
  typedef struct {logic [511:0] d; logic l; logic u;} beat_t;
  typedef int a8_t [8];
  logic clk = 0;
  logic rst_n = 1;
  logic bp_en = 0;
  logic rdy_fix = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_out = 0;
  int n_last = 0;
  beat_t exp_q [$];
  always #5 clk = ~clk;
  fft_8point_dft_if #(.DW(64), .UW(1)) s_if ();
  fft_8point_dft_if #(.DW(512), .UW(1)) m_if ();
  fft_8point_dft dut (.s_axis_aclk(clk), .s_axis_areset(rst_n), .s_axis(s_if), .m_axis(m_if));
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic cpx_t rot(input cpx_t z, input int p);
    cpx_t y;
    longint t;
    y = z;
    for (int n = 0; n < p % 4; n++) begin
      t = y.r;
      y.r = y.i;
      y.i = -t;
    end
    return y;
  endfunction
  function automatic logic [511:0] model(input logic [63:0] td);
    longint x [8];
    cpx_t ak [4];
    cpx_t bk [4];
    cpx_t z, se, so;
    longint dv, p;
    logic [511:0] res;
    res = '0;
    for (int k = 0; k < 8; k++) x[k] = longint'($signed(td[8*k +: 8]));
    for (int k = 0; k < 4; k++) begin
      dv = x[k] - x[k+4];
      ak[k].r = x[k] + x[k+4];
      ak[k].i = 0;
      if (k % 2 == 0) begin
        z.r = dv;
        z.i = 0;
      end else begin
        p = (dv * 23170) >>> 15;
        z.r = p;
        z.i = -p;
      end
      bk[k] = rot(z, k / 2);
    end
    for (int m = 0; m < 4; m++) begin
      se.r = 0; se.i = 0; so.r = 0; so.i = 0;
      for (int k = 0; k < 4; k++) begin
        z = rot(ak[k], m * k);
        se.r += z.r; se.i += z.i;
        z = rot(bk[k], m * k);
        so.r += z.r; so.i += z.i;
      end
      res[128*m +: 64] = {32'(se.r), 32'(se.i)};
      res[128*m+64 +: 64] = {32'(so.r), 32'(so.i)};
    end
    return res;
  endfunction
  function automatic logic [511:0] pk(input a8_t re, input a8_t im);
    logic [511:0] res;
    for (int k = 0; k < 8; k++) res[64*k +: 64] = {re[k], im[k]};
    return res;
  endfunction
  task automatic chk_bin(input string tag, input int k, input int re, input int im);
    logic [63:0] e;
    e = {re, im};
    chk(tag, m_if.tdata[64*k +: 64], e);
  endtask
  task automatic wait_accept(input string tag);
    int t = 0;
    logic acc = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      t++;
    end
    chk(tag, acc, 1);
  endtask
  task automatic send(input logic [63:0] td);
    s_if.tvalid = 1;
    s_if.tdata = td;
    s_if.tlast = 0;
    s_if.tuser = 0;
    wait_accept("accept");
    s_if.tvalid = 0;
    repeat (3) begin
      chk("latency_early", m_if.tvalid, 0);
      @(posedge clk);
      #1;
    end
    chk("latency_valid", m_if.tvalid, 1);
  endtask
  initial begin
    m_if.tready = 0;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = bp_en ? ($urandom_range(0, 2) != 0) : rdy_fix;
    end
  end
  initial begin
    beat_t e;
    logic stalled = 0;
    logic [511:0] held_d;
    logic held_l, held_u;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        stalled = 0;
      end else begin
        if (stalled) begin
          chk("stall_valid", m_if.tvalid, 1);
          chk("stall_data", m_if.tdata, held_d);
          chk("stall_last", m_if.tlast, held_l);
          chk("stall_user", m_if.tuser, held_u);
        end
        chk("tready_rule", s_if.tready, !(m_if.tvalid && !m_if.tready));
        if (m_if.tvalid && m_if.tready) begin
          chk("out_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", m_if.tdata, e.d);
            chk("out_last", m_if.tlast, e.l);
            chk("out_user", m_if.tuser, e.u);
            n_out++;
            if (m_if.tlast) n_last++;
          end
        end
        stalled = m_if.tvalid && !m_if.tready;
        held_d = m_if.tdata;
        held_l = m_if.tlast;
        held_u = m_if.tuser;
        if (s_if.tvalid && s_if.tready) begin
          e.d = model(s_if.tdata);
          e.l = s_if.tlast;
          e.u = s_if.tuser;
          exp_q.push_back(e);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    int t, n0, l0;
    s_if.tvalid = 0;
    s_if.tdata = '0;
    s_if.tlast = 0;
    s_if.tuser = 0;
    s_if.tkeep = '1;
    s_if.tstrb = '1;
    #1 rst_n = 0;
    #1;
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_tready", s_if.tready, 1);
    chk("rst_tdata", m_if.tdata, '0);
    s_if.tvalid = 1;
    s_if.tdata = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    s_if.tvalid = 0;
    rst_n = 1;
    rdy_fix = 1;
    chk("tkeep", m_if.tkeep, {64{1'b1}});
    chk("tstrb", m_if.tstrb, {64{1'b1}});
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("no_capture_in_rst", m_if.tvalid, 0);
    end
    send(64'h01);
    chk("impulse", m_if.tdata, pk('{1, 1, 1, 1, 1, 1, 1, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}));
    send(64'h0101010101010101);
    chk("dc", m_if.tdata, pk('{8, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}));
    send(64'h6400);
    chk("x1_100", m_if.tdata, pk('{100, 70, 0, -70, -100, -70, 0, 70}, '{0, -70, -100, -70, 0, 70, 100, 70}));
    send(64'h9C00);
    chk_bin("x1_m100_bin1", 1, -71, 71);
    chk_bin("x1_m100_bin3", 3, 71, 71);
    send(64'hFF01FF01FF01FF01);
    chk("alternating", m_if.tdata, pk('{0, 0, 0, 0, 8, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}));
    @(posedge clk);
    #1;
    n0 = n_out;
    l0 = n_last;
    bp_en = 1;
    for (int b = 0; b < 16; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_if.tvalid = 0;
        @(posedge clk);
        #1;
      end
      s_if.tvalid = 1;
      s_if.tdata = {$urandom, $urandom};
      s_if.tlast = (b == 15);
      s_if.tuser = 1'($urandom);
      s_if.tkeep = 8'($urandom);
      wait_accept("bp_accept");
    end
    s_if.tvalid = 0;
    s_if.tlast = 0;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bp_drain", exp_q.size(), 0);
    chk("bp_count", n_out - n0, 16);
    chk("bp_last_count", n_last - l0, 1);
    bp_en = 0;
    repeat (3) @(posedge clk);
    #1;
    s_if.tvalid = 1;
    s_if.tuser = 0;
    for (int b = 0; b < 4; b++) begin
      s_if.tdata = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    chk("pre_rst_valid", m_if.tvalid, 1);
    rst_n = 0;
    s_if.tdata = {$urandom, $urandom};
    #1;
    chk("rst_async_valid", m_if.tvalid, 0);
    chk("rst_async_data", m_if.tdata, '0);
    @(posedge clk);
    #1;
    rst_n = 1;
    s_if.tvalid = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("no_stale", m_if.tvalid, 0);
    end
    n0 = n_out;
    send({$urandom, $urandom});
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_out", n_out - n0, 1);
    chk("final_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
